axi_wr_arbiter: RTL and testbench
=================================

// Module: axi_wr_arbiter
// PURPOSE
//  Two-master to one-slave AXI write-path arbiter in front of AXI_top_design's slave port. Round-robin
//  grant on AW, lock through the W burst, then route the B response to the winner. One outstanding
//  write at a time. Read channels are not handled here.
// PARAMETERS
//  WIDTH  32  address/data width; ID, LEN and STRB are WIDTH/8 bits wide
//  SIZE   3   AxSIZE width; AxBURST and BRESP are SIZE-1 bits wide
// PORTS  (m_* ports are packed [1:0] arrays indexed by master number)
//  clk                          in   1            single clock, rising edge
//  resetn                       in   1            asynchronous, active-low reset
//  m_awvalid / m_awready        in/out 2          per-master AW handshake
//  m_awaddr,id,len,size,burst   in   [1:0][..]    per-master AW payload
//  m_wvalid,wlast / m_wready    in/out 2          per-master W handshake
//  m_wdata / m_wstrb            in   [1:0][WIDTH] / [1:0][WIDTH/8]  per-master W payload
//  m_bvalid / m_bready          out/in 2          per-master B handshake
//  m_bid / m_bresp              out  WIDTH/8 / SIZE-1  shared B payload, valid only with m_bvalid
//  s_awvalid / s_awready        out/in 1          slave AW handshake
//  s_awaddr,id,len,size,burst   out  as AW        muxed AW payload
//  s_wvalid,wlast / s_wready    out/in 1          slave W handshake
//  s_wdata / s_wstrb            out  WIDTH / WIDTH/8  muxed W payload
//  s_bvalid,bid,bresp / s_bready  in/out          slave B channel
//  gnt                          out  1            currently granted master
//  busy                         out  1            1 whenever state != IDLE
//  err_wlast                    out  1            1-cycle pulse on a WLAST/beat-count mismatch
// BEHAVIOUR
//  FSM states: IDLE -> ADDR -> DATA -> RESP -> IDLE.
//  IDLE: if any m_awvalid is set, pick with round-robin. Priority goes to !last_gnt. Register gnt, go to ADDR.
//    Latency: m_awvalid rising at cycle n gives s_awvalid at n+1.
//  ADDR: s_awvalid=1. s_aw* is muxed from the registered gnt. m_awready[gnt]=s_awready.
//    On the AW handshake, latch awlen, clear beat_cnt (5 bits), go to DATA.
//  DATA: s_wvalid=m_wvalid[gnt]; m_wready[gnt]=s_wready; s_wlast=m_wlast[gnt].
//    beat_cnt increments on each W handshake.
//    On a handshake with wlast=1, go to RESP.
//    If wlast arrives with beat_cnt!=awlen, or beat_cnt==awlen arrives without wlast, pulse err_wlast.
//    The FSM still advances only on wlast.
//  RESP: m_bvalid[gnt]=s_bvalid; s_bready=m_bready[gnt]; bid/bresp pass through.
//    On the B handshake: last_gnt<=gnt, go to IDLE.
//  Non-granted master: awready, wready and bvalid are held 0. W beats offered before DATA are not accepted.
//  Requests arriving mid-transaction wait. A new arbitration happens only in IDLE, so there is one idle cycle between transactions.
//  Reset (asynchronous, any state): state=IDLE, gnt=0, last_gnt=1 (master 0 wins first), beat_cnt=0.
//    All valid/ready outputs and err_wlast=0. Payload outputs=0.
//    The slave shares resetn, so a burst in flight is dropped.
// CONFIGURATION
//  AXI_WR_ARB_STATS_EN defined: adds output grant_cnt [1:0][15:0].
//    grant_cnt[i] increments on each B handshake for master i and saturates at 16'hFFFF. Reset value is 0.
//  Macro undefined: port and counters are absent. All other behaviour is identical.
// STRUCTURE
//  axi_arb_pkg holds arb_state_e {IDLE,ADDR,DATA,RESP}, the BEAT_CNT_W=5 localparam and BRESP codes (OKAY=0, SLVERR=2).
//  One sub-module, axi_rr_picker: a 2-way round-robin picker.
//    Inputs: req[1:0], last_gnt. Outputs: gnt_valid, gnt. Combinational.
// TESTING
//  1 m0 alone, awaddr=0x100, awlen=3: s_awaddr=0x100 one cycle later; 4 beats forwarded;
//    B OKAY reaches m0 only; m_bvalid[1] stays 0.
//  2 m0 and m1 request together right after reset: m0 served, then m1, then m0 again (alternation holds).
//  3 m1 drives wvalid before its AW is granted: m_wready[1]=0 until DATA; no beat is lost or duplicated.
//  4 awlen=2 with wlast on beat 2 of 3: err_wlast pulses once; FSM enters RESP; B still routed to the owner.
//  5 resetn low mid-DATA: outputs 0 immediately; after release, state IDLE and m0 wins the first contest.
//  6 With STATS_EN: 3 m0 + 1 m1 writes give grant_cnt = {1,3}. Without STATS_EN: the build has no grant_cnt port.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI write-path arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } arb_state_e;

  localparam int BEAT_CNT_W = 5;

  localparam logic [1:0] BRESP_OKAY   = 2'd0;
  localparam logic [1:0] BRESP_SLVERR = 2'd2;

endpackage

// File: rtl/axi_wr_arbiter_if.sv
// Write-channel bundle around the arbiter: two upstream masters (m_*) and one downstream slave (s_*).
interface axi_wr_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 3
);
  localparam int IW = WIDTH / 8;
  localparam int BW = SIZE - 1;

  logic [1:0]                 m_awvalid;
  logic [1:0]                 m_awready;
  logic [1:0][WIDTH-1:0]      m_awaddr;
  logic [1:0][IW-1:0]         m_awid;
  logic [1:0][IW-1:0]         m_awlen;
  logic [1:0][SIZE-1:0]       m_awsize;
  logic [1:0][BW-1:0]         m_awburst;
  logic [1:0]                 m_wvalid;
  logic [1:0]                 m_wlast;
  logic [1:0]                 m_wready;
  logic [1:0][WIDTH-1:0]      m_wdata;
  logic [1:0][IW-1:0]         m_wstrb;
  logic [1:0]                 m_bvalid;
  logic [1:0]                 m_bready;
  logic [IW-1:0]              m_bid;
  logic [BW-1:0]              m_bresp;

  logic                       s_awvalid;
  logic                       s_awready;
  logic [WIDTH-1:0]           s_awaddr;
  logic [IW-1:0]              s_awid;
  logic [IW-1:0]              s_awlen;
  logic [SIZE-1:0]            s_awsize;
  logic [BW-1:0]              s_awburst;
  logic                       s_wvalid;
  logic                       s_wlast;
  logic                       s_wready;
  logic [WIDTH-1:0]           s_wdata;
  logic [IW-1:0]              s_wstrb;
  logic                       s_bvalid;
  logic                       s_bready;
  logic [IW-1:0]              s_bid;
  logic [BW-1:0]              s_bresp;

  // Upstream masters' view
  modport master (
    output m_awvalid, m_awaddr, m_awid, m_awlen, m_awsize, m_awburst,
    output m_wvalid, m_wlast, m_wdata, m_wstrb, m_bready,
    input  m_awready, m_wready, m_bvalid, m_bid, m_bresp
  );

  // Downstream slave's view
  modport slave (
    input  s_awvalid, s_awaddr, s_awid, s_awlen, s_awsize, s_awburst,
    input  s_wvalid, s_wlast, s_wdata, s_wstrb, s_bready,
    output s_awready, s_wready, s_bvalid, s_bid, s_bresp
  );

  // Arbiter: slave toward the masters, master toward the slave
  modport arb (
    input  m_awvalid, m_awaddr, m_awid, m_awlen, m_awsize, m_awburst,
    input  m_wvalid, m_wlast, m_wdata, m_wstrb, m_bready,
    output m_awready, m_wready, m_bvalid, m_bid, m_bresp,
    output s_awvalid, s_awaddr, s_awid, s_awlen, s_awsize, s_awburst,
    output s_wvalid, s_wlast, s_wdata, s_wstrb, s_bready,
    input  s_awready, s_wready, s_bvalid, s_bid, s_bresp
  );

endinterface

// File: rtl/axi_rr_picker.sv
// Two-way round-robin picker: on a tie the master that did not win last time is chosen.
module axi_rr_picker (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt
);

  assign gnt_valid = |req;
  assign gnt       = (&req) ? ~last_gnt : req[1];

endmodule

// File: rtl/axi_wr_arbiter.sv
// Two-master to one-slave AXI write arbiter; one outstanding write, AW->W->B locked to the winner.
// Optional per-master grant counters are built when AXI_WR_ARB_STATS_EN is defined.
module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SIZE  = 3
) (
  input  logic              clk,
  input  logic              resetn,
  axi_wr_arbiter_if.arb     bus,
  output logic              gnt,
  output logic              busy,
  output logic              err_wlast
`ifdef AXI_WR_ARB_STATS_EN
  ,
  output logic [1:0][15:0]  grant_cnt
`endif
);

  localparam int IW      = WIDTH / 8;
  localparam int BRESP_W = SIZE - 1;

  arb_state_e              state;
  logic                    last_gnt;
  logic [BEAT_CNT_W-1:0]   beat_cnt;
  logic [IW-1:0]           awlen;
  logic                    pick_valid;
  logic                    pick_gnt;
  logic                    aw_hs;
  logic                    w_hs;
  logic                    b_hs;
  logic                    wlast_sel;
  logic                    last_beat;

  axi_rr_picker u_picker (
    .req       (bus.m_awvalid),
    .last_gnt  (last_gnt),
    .gnt_valid (pick_valid),
    .gnt       (pick_gnt)
  );

  assign aw_hs     = (state == ADDR) && bus.s_awready;
  assign w_hs      = (state == DATA) && bus.m_wvalid[gnt] && bus.s_wready;
  assign b_hs      = (state == RESP) && bus.s_bvalid && bus.m_bready[gnt];
  assign wlast_sel = bus.m_wlast[gnt];
  assign last_beat = (beat_cnt == BEAT_CNT_W'(awlen));
  assign busy      = (state != IDLE);

  // Every slave-facing payload is forced to zero outside its own phase, so reset clears them at once.
  always_comb begin
    bus.m_awready = 2'b00;
    bus.m_wready  = 2'b00;
    bus.m_bvalid  = 2'b00;
    bus.m_bid     = {IW{1'b0}};
    bus.m_bresp   = {BRESP_W{1'b0}};
    bus.s_awvalid = 1'b0;
    bus.s_awaddr  = {WIDTH{1'b0}};
    bus.s_awid    = {IW{1'b0}};
    bus.s_awlen   = {IW{1'b0}};
    bus.s_awsize  = {SIZE{1'b0}};
    bus.s_awburst = {BRESP_W{1'b0}};
    bus.s_wvalid  = 1'b0;
    bus.s_wlast   = 1'b0;
    bus.s_wdata   = {WIDTH{1'b0}};
    bus.s_wstrb   = {IW{1'b0}};
    bus.s_bready  = 1'b0;
    case (state)
      ADDR: begin
        bus.s_awvalid      = 1'b1;
        bus.s_awaddr       = bus.m_awaddr[gnt];
        bus.s_awid         = bus.m_awid[gnt];
        bus.s_awlen        = bus.m_awlen[gnt];
        bus.s_awsize       = bus.m_awsize[gnt];
        bus.s_awburst      = bus.m_awburst[gnt];
        bus.m_awready[gnt] = bus.s_awready;
      end
      DATA: begin
        bus.s_wvalid      = bus.m_wvalid[gnt];
        bus.s_wlast       = wlast_sel;
        bus.s_wdata       = bus.m_wdata[gnt];
        bus.s_wstrb       = bus.m_wstrb[gnt];
        bus.m_wready[gnt] = bus.s_wready;
      end
      RESP: begin
        bus.m_bvalid[gnt] = bus.s_bvalid;
        bus.s_bready      = bus.m_bready[gnt];
        bus.m_bid         = bus.s_bid;
        bus.m_bresp       = bus.s_bresp;
      end
      default: begin
      end
    endcase
  end

  // Control FSM; last_gnt starts at 1 so master 0 wins the first contest.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      last_gnt  <= 1'b1;
      beat_cnt  <= '0;
      awlen     <= '0;
      err_wlast <= 1'b0;
    end else begin
      err_wlast <= w_hs && (wlast_sel != last_beat);
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt   <= pick_gnt;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (aw_hs) begin
            awlen    <= bus.m_awlen[gnt];
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
            if (wlast_sel) state <= RESP;
          end
        end
        RESP: begin
          if (b_hs) begin
            last_gnt <= gnt;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXI_WR_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_cnt <= '0;
    end else if (b_hs) begin
      grant_cnt[gnt] <= sat_inc(grant_cnt[gnt]);
    end
  end
`endif

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Randomized bench for axi_wr_arbiter: transaction-level masters/slave plus a scoreboard model.
`timescale 1ns/1ps
module tb_axi_wr_arbiter;
  import axi_arb_pkg::*;

  localparam int WIDTH = 32;
  localparam int SIZE  = 3;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          nbeats;
    logic [31:0] seed;
  } txn_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic gnt, busy, err_wlast;
`ifdef AXI_WR_ARB_STATS_EN
  logic [1:0][15:0] grant_cnt;
`endif

  axi_wr_arbiter_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus ();

  axi_wr_arbiter #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .gnt       (gnt),
    .busy      (busy),
    .err_wlast (err_wlast)
`ifdef AXI_WR_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  txn_t mq [2][$];
  txn_t eq [2][$];
  txn_t cur [2];
  bit   act [2];
  int   beat [2];
  bit   eager;
  bit   free_m;
  bit   last_win;
  bit   chk_aw;
  bit   aw_seen;
  int   win;
  int   beats_seen;
  int   err_seen;
  int   err_exp;
  txn_t exp_t;
  int   win_log [$];
  int   gc [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] bdata(input txn_t t, input int k);
    return t.seed + 32'(k) * 32'h0101_0101;
  endfunction

  function automatic logic [3:0] bstrb(input txn_t t, input int k);
    return t.seed[3:0] ^ 4'(k);
  endfunction

  // A beat is flagged when "carries wlast" and "is beat number awlen" disagree.
  function automatic int exp_errs(input txn_t t);
    int n = 0;
    for (int k = 0; k < t.nbeats; k++)
      if ((k == t.nbeats - 1) != (k == int'(t.len))) n++;
    return n;
  endfunction

  function automatic int rr_pick(input logic [1:0] req, input bit last);
    if (req[0] && req[1]) return last ? 0 : 1;
    return req[1] ? 1 : 0;
  endfunction

  function automatic txn_t mk(input logic [31:0] a, input logic [3:0] len, input int nb);
    txn_t t;
    t.addr = a; t.id = 4'($urandom); t.len = len; t.size = 3'($urandom);
    t.burst = 2'($urandom); t.nbeats = nb; t.seed = $urandom;
    return t;
  endfunction

  task automatic push(input int m, input txn_t t);
    mq[m].push_back(t);
    eq[m].push_back(t);
  endtask

  task automatic clear_all();
    bus.m_awvalid = '0; bus.m_awaddr = '0; bus.m_awid = '0; bus.m_awlen = '0;
    bus.m_awsize = '0; bus.m_awburst = '0; bus.m_wvalid = '0; bus.m_wlast = '0;
    bus.m_wdata = '0; bus.m_wstrb = '0; bus.m_bready = '0;
    bus.s_awready = 1'b0; bus.s_wready = 1'b0; bus.s_bvalid = 1'b0;
    bus.s_bid = '0; bus.s_bresp = '0;
    for (int i = 0; i < 2; i++) begin
      mq[i].delete(); eq[i].delete(); act[i] = 1'b0; beat[i] = 0; gc[i] = 0;
    end
    free_m = 1'b1; last_win = 1'b1; chk_aw = 1'b0; aw_seen = 1'b0;
    win = 0; beats_seen = 0; err_seen = 0; err_exp = 0;
    win_log.delete();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_all();
    @(posedge clk); #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_wlast, 0);
    chk("rst_handshake", {bus.s_awvalid, bus.s_wvalid, bus.s_bready,
                          bus.m_awready, bus.m_wready, bus.m_bvalid}, 0);
    chk("rst_payload", {bus.s_awaddr, bus.s_wdata}, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // Scoreboard, evaluated once per cycle at the falling edge.
  task automatic monitor();
    int o;
    if (err_wlast) err_seen++;
    if (chk_aw) begin
      chk("aw_latency", bus.s_awvalid, 1);
      chk("gnt", gnt, win);
      chk("busy", busy, 1);
      chk("aw_addr_early", bus.s_awaddr, exp_t.addr);
      chk_aw = 1'b0;
    end
    if (free_m) begin
      chk("idle_busy", busy, 0);
      chk("idle_outs", {bus.s_awvalid, bus.s_wvalid, bus.s_bready,
                        bus.m_awready, bus.m_wready, bus.m_bvalid}, 0);
      if (bus.m_awvalid != 2'b00) begin
        win = rr_pick(bus.m_awvalid, last_win);
        free_m = 1'b0;
        chk_aw = 1'b1;
        if (eq[win].size() == 0) chk("eq_underflow", 1, 0);
        else exp_t = eq[win].pop_front();
        beats_seen = 0; aw_seen = 1'b0; err_seen = 0;
        err_exp = exp_errs(exp_t);
        win_log.push_back(win);
      end
    end else begin
      o = 1 - win;
      chk("loser_quiet", {bus.m_awready[o], bus.m_wready[o], bus.m_bvalid[o]}, 0);
      if (bus.s_awvalid && bus.s_awready) begin
        chk("aw_payload", {bus.s_awaddr, bus.s_awid, bus.s_awlen, bus.s_awsize, bus.s_awburst},
            {exp_t.addr, exp_t.id, exp_t.len, exp_t.size, exp_t.burst});
        aw_seen = 1'b1;
      end
      if (bus.s_wvalid && bus.s_wready) begin
        chk("w_after_aw", aw_seen, 1);
        chk("w_beat", {bus.s_wdata, bus.s_wstrb, bus.s_wlast},
            {bdata(exp_t, beats_seen), bstrb(exp_t, beats_seen), beats_seen == exp_t.nbeats - 1});
        beats_seen++;
      end
      if (bus.m_bvalid[win] && bus.m_bready[win]) begin
        chk("b_payload", {bus.m_bid, bus.m_bresp}, {bus.s_bid, bus.s_bresp});
        chk("beat_count", beats_seen, exp_t.nbeats);
        chk("err_wlast", err_seen, err_exp);
        last_win = win[0];
        gc[win]++;
        free_m = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    logic [1:0] awh, wh, bh;
    logic swl, sbh;
    @(negedge clk);
    awh = bus.m_awvalid & bus.m_awready;
    wh  = bus.m_wvalid & bus.m_wready;
    bh  = bus.m_bvalid & bus.m_bready;
    swl = bus.s_wvalid & bus.s_wready & bus.s_wlast;
    sbh = bus.s_bvalid & bus.s_bready;
    monitor();
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      if (awh[i]) bus.m_awvalid[i] = 1'b0;
      if (wh[i]) begin beat[i]++; bus.m_wvalid[i] = 1'b0; end
      if (bh[i]) act[i] = 1'b0;
      if (!act[i] && mq[i].size() > 0 && (eager || $urandom_range(0, 2) == 0)) begin
        cur[i] = mq[i].pop_front();
        act[i] = 1'b1; beat[i] = 0;
        bus.m_awvalid[i] = 1'b1;
        bus.m_awaddr[i] = cur[i].addr; bus.m_awid[i] = cur[i].id; bus.m_awlen[i] = cur[i].len;
        bus.m_awsize[i] = cur[i].size; bus.m_awburst[i] = cur[i].burst;
      end
      if (act[i] && beat[i] < cur[i].nbeats && !bus.m_wvalid[i] && $urandom_range(0, 3) != 0) begin
        bus.m_wvalid[i] = 1'b1;
        bus.m_wdata[i]  = bdata(cur[i], beat[i]);
        bus.m_wstrb[i]  = bstrb(cur[i], beat[i]);
        bus.m_wlast[i]  = (beat[i] == cur[i].nbeats - 1);
      end
      bus.m_bready[i] = ($urandom_range(0, 3) != 0);
    end
    bus.s_awready = ($urandom_range(0, 2) != 0);
    bus.s_wready  = ($urandom_range(0, 3) != 0);
    if (sbh) bus.s_bvalid = 1'b0;
    if (swl) begin
      bus.s_bvalid = 1'b1;
      bus.s_bid    = 4'($urandom);
      bus.s_bresp  = $urandom_range(0, 1) ? BRESP_SLVERR : BRESP_OKAY;
    end
  endtask

  function automatic bit all_done();
    return free_m && !act[0] && !act[1] && mq[0].size() == 0 && mq[1].size() == 0 &&
           eq[0].size() == 0 && eq[1].size() == 0;
  endfunction

  task automatic run(input int budget);
    int n = 0;
    while (n < budget && !all_done()) begin
      cycle();
      n++;
    end
    chk("phase_done", n < budget, 1);
  endtask

  initial begin
    int n;
    eager = 1'b1;
    do_reset();

    // Single master, 4-beat burst at 0x100
    push(0, mk(32'h100, 4'd3, 4));
    run(500);
    chk("t1_one_grant", win_log.size(), 1);
    chk("t1_winner", win_log[0], 0);

    // Simultaneous requests after reset alternate starting with m0
    do_reset();
    push(0, mk(32'h1000, 4'd1, 2));
    push(0, mk(32'h2000, 4'd2, 3));
    push(1, mk(32'h3000, 4'd0, 1));
    run(1000);
    chk("t2_order", (win_log.size() == 3) ? (win_log[0] * 4 + win_log[1] * 2 + win_log[2]) : -1, 2);

    // m1 offers W beats while m0 holds a long burst
    do_reset();
    push(0, mk(32'h4000, 4'd7, 8));
    push(1, mk(32'h5000, 4'd3, 4));
    run(1000);

    // WLAST / beat-count mismatches
    do_reset();
    push(0, mk(32'h6000, 4'd2, 2));
    push(1, mk(32'h7000, 4'd1, 3));
    push(0, mk(32'h8000, 4'd0, 1));
    push(1, mk(32'h9000, 4'd3, 6));
    run(2000);

    // Asynchronous reset in the middle of a data burst
    do_reset();
    push(0, mk(32'hA000, 4'd7, 8));
    n = 0;
    while (!(aw_seen && beats_seen >= 1) && n < 300) begin cycle(); n++; end
    chk("t5_in_data", aw_seen && beats_seen >= 1, 1);
    #2 resetn = 1'b0;
    #1;
    chk("t5_async_outs", {bus.s_awvalid, bus.s_wvalid, bus.s_bready, bus.m_awready,
                          bus.m_wready, bus.m_bvalid, busy, err_wlast}, 0);
    chk("t5_async_payload", {bus.s_wdata, bus.s_wstrb, bus.s_awaddr}, 0);
    do_reset();
    push(0, mk(32'hB000, 4'd1, 2));
    push(1, mk(32'hC000, 4'd1, 2));
    run(1000);
    chk("t5_first_winner", win_log[0], 0);

`ifdef AXI_WR_ARB_STATS_EN
    do_reset();
    for (int k = 0; k < 3; k++) push(0, mk(32'hD000 + 32'(k * 16), 4'd0, 1));
    push(1, mk(32'hE000, 4'd0, 1));
    run(1000);
    chk("t6_grant_cnt", grant_cnt, {16'd1, 16'd3});
`endif

    // Randomized mix
    do_reset();
    eager = 1'b0;
    for (int k = 0; k < 40; k++) begin
      logic [3:0] len;
      int nb;
      len = 4'($urandom_range(0, 7));
      nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : int'(len) + 1;
      push($urandom_range(0, 1), mk($urandom, len, nb));
    end
    run(20000);
`ifdef AXI_WR_ARB_STATS_EN
    chk("rand_grant_cnt", grant_cnt, {16'(gc[1]), 16'(gc[0])});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
